ysyx_exu_csr_exec: RTL
======================

Name: ysyx_exu_csr_exec

Overview:
- Execute-stage sequencer directly upstream of the CSR register file; handles CSR instructions (CSRRW/S/C and immediate forms), ECALL and MRET.
- Accepts one decoded instruction from IDU, reads the CSR, issues the read-modify-write or trap update on the register file's write ports, and returns the rd result and PC redirect to WBU.
- Valid/ready on both sides; one instruction in flight.

Parameters:
- BIT_W, 32, datapath width.
- R_W, 12, CSR address width.
- MCAUSE_ECALL_M, 32'd11, mcause value written on ECALL.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IDU instruction valid
- in_ready  out  1  block can accept an instruction
- in_sys  in  2  0=CSR op, 1=ECALL, 2=MRET, 3=reserved
- in_funct3  in  3  CSR op: 1 RW, 2 RS, 3 RC, 5 RWI, 6 RSI, 7 RCI
- in_csr_addr  in  R_W  CSR address
- in_rs1_idx  in  5  rs1 index; used as zimm for immediate forms
- in_rs1_val  in  BIT_W  rs1 value
- in_rd  in  5  destination register
- in_pc  in  BIT_W  instruction PC
- csr_waddr  out  R_W  CSR address (read and primary write)
- csr_waddr_add1  out  R_W  secondary write address
- csr_wdata  out  BIT_W  primary write data
- csr_wdata_add1  out  BIT_W  secondary write data
- csr_wen  out  1  write enable
- csr_ecallen  out  1  ECALL mstatus update
- csr_exu_valid  out  1  qualifies wen/ecallen
- csr_rdata  in  BIT_W  combinational read of csr_waddr
- csr_mtvec  in  BIT_W  current mtvec
- csr_mepc  in  BIT_W  current mepc
- out_valid  out  1  result valid to WBU
- out_ready  in  1  WBU accepts
- out_rd  out  5  destination register
- out_rd_wen  out  1  rd write required
- out_rdata  out  BIT_W  old CSR value
- out_redirect  out  1  PC redirect required
- out_npc  out  BIT_W  redirect target

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (rst=0, asynchronous) → IDLE. While reset is asserted: all outputs 0, including in_ready.
- IDLE: in_ready=1. On in_valid&in_ready, latch all in_* fields → EXEC.
- EXEC (exactly 1 cycle): csr_waddr = latched addr. Compute the operand: RW/RS/RC use rs1_val; I-forms use zero-extended in_rs1_idx.
  - new = RW: operand; RS: rdata|operand; RC: rdata&~operand.
  - Write is suppressed for RS/RC/RSI/RCI when in_rs1_idx==0. RW and RWI always write.
  - When writing: csr_exu_valid=1, csr_wen=1, csr_wdata=new, csr_waddr_add1=csr_waddr, csr_wdata_add1=new (duplicate write is intentional).
  - Latch out_rdata=csr_rdata, out_rd_wen=(rd!=0).
- ECALL in EXEC:
  - csr_waddr=MEPC (0x341), csr_wdata=pc; csr_waddr_add1=MCAUSE (0x342), csr_wdata_add1=MCAUSE_ECALL_M.
  - csr_wen=1, csr_ecallen=1, csr_exu_valid=1.
  - Latch out_redirect=1, out_npc=csr_mtvec, out_rd_wen=0.
- MRET in EXEC: no write, csr_exu_valid=0. Latch out_redirect=1, out_npc=csr_mepc, out_rd_wen=0.
- Illegal funct3 (0 or 4) or in_sys=3: no write, out_rd_wen=0, out_redirect=0. Still completes through RESP.
- csr_wen, csr_ecallen and csr_exu_valid are high only in EXEC and for one cycle per instruction. They are 0 in IDLE and RESP.
- RESP: out_valid=1 with stable out_* until out_ready. On the handshake → IDLE. in_ready=0.
- Latency: accept at cycle N, CSR write at N+1, out_valid from N+2. Back-to-back throughput is one instruction per 3 cycles (out_ready held high).
- A following instruction reads the value written by the previous one, because the write lands at the end of EXEC.
- Reset asserted in EXEC aborts immediately: write strobes drop asynchronously, no partial write, no output.
- out_* registers are cleared on reset. out_valid is deasserted only by the handshake or by reset.

Test Plan:
- CSRRW: mtvec=0, rs1_val=0x80000100, rd=5 → at N+1 wen=1, waddr=0x305, wdata=0x80000100. At N+2 out_valid, out_rdata=0, out_rd_wen=1.
- CSRRS with in_rs1_idx=0 on mstatus=0x1888 → csr_wen never asserts. out_rdata=0x1888.
- CSRRCI zimm=0x8 on mstatus=0x0088 → wdata=0x0080. Then CSRRSI zimm=0x8 immediately after → out_rdata=0x0080, wdata=0x0088.
- ECALL pc=0x80000010, mtvec=0x80000200 → same cycle: mepc←0x80000010, mcause←11, ecallen=1. out_redirect=1, out_npc=0x80000200, out_rd_wen=0.
- MRET with mepc=0x80000014, out_ready held low 3 cycles → out_valid held stable 3 cycles, no CSR write, in_ready=0. Accepts again the cycle after the handshake.
- Reset pulsed low during EXEC of CSRRW → wen drops asynchronously, mtvec unchanged, FSM returns to IDLE, out_valid=0.

Source files
------------

// File: rtl/ysyx_exu_csr_exec_if.sv
// Bundle between the CSR execute sequencer and its neighbours: IDU request,
// CSR register-file read/write ports and WBU response.
//   slave  : view of the sequencer (ysyx_exu_csr_exec)
//   master : view of the surrounding pipeline / register file
interface ysyx_exu_csr_exec_if #(
  parameter int unsigned BIT_W = 32,
  parameter int unsigned R_W   = 12
);
  // IDU -> EXU request
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sys;
  logic [2:0]       in_funct3;
  logic [R_W-1:0]   in_csr_addr;
  logic [4:0]       in_rs1_idx;
  logic [BIT_W-1:0] in_rs1_val;
  logic [4:0]       in_rd;
  logic [BIT_W-1:0] in_pc;

  // CSR register-file ports
  logic [R_W-1:0]   csr_waddr;
  logic [R_W-1:0]   csr_waddr_add1;
  logic [BIT_W-1:0] csr_wdata;
  logic [BIT_W-1:0] csr_wdata_add1;
  logic             csr_wen;
  logic             csr_ecallen;
  logic             csr_exu_valid;
  logic [BIT_W-1:0] csr_rdata;
  logic [BIT_W-1:0] csr_mtvec;
  logic [BIT_W-1:0] csr_mepc;

  // EXU -> WBU response
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rd;
  logic             out_rd_wen;
  logic [BIT_W-1:0] out_rdata;
  logic             out_redirect;
  logic [BIT_W-1:0] out_npc;

  modport slave (
    input  in_valid, in_sys, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val,
           in_rd, in_pc, csr_rdata, csr_mtvec, csr_mepc, out_ready,
    output in_ready, csr_waddr, csr_waddr_add1, csr_wdata, csr_wdata_add1,
           csr_wen, csr_ecallen, csr_exu_valid, out_valid, out_rd,
           out_rd_wen, out_rdata, out_redirect, out_npc
  );

  modport master (
    output in_valid, in_sys, in_funct3, in_csr_addr, in_rs1_idx, in_rs1_val,
           in_rd, in_pc, csr_rdata, csr_mtvec, csr_mepc, out_ready,
    input  in_ready, csr_waddr, csr_waddr_add1, csr_wdata, csr_wdata_add1,
           csr_wen, csr_ecallen, csr_exu_valid, out_valid, out_rd,
           out_rd_wen, out_rdata, out_redirect, out_npc
  );
endinterface

// File: rtl/ysyx_exu_csr_exec.sv
// Execute-stage sequencer for CSR instructions, ECALL and MRET.
// Accepts one instruction (IDLE), performs the CSR read-modify-write or trap
// update for exactly one cycle (EXEC), then holds the result for WBU (RESP).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - request / CSR register-file / response bundle (slave view)
module ysyx_exu_csr_exec #(
  parameter int unsigned      BIT_W          = 32,
  parameter int unsigned      R_W            = 12,
  parameter logic [BIT_W-1:0] MCAUSE_ECALL_M = BIT_W'(11)
) (
  input logic                clk,
  input logic                rst,
  ysyx_exu_csr_exec_if.slave bus
);

  localparam logic [R_W-1:0] MEPC_ADDR   = R_W'(12'h341);
  localparam logic [R_W-1:0] MCAUSE_ADDR = R_W'(12'h342);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  // Latched instruction fields
  logic [1:0]       r_sys;
  logic [2:0]       r_funct3;
  logic [R_W-1:0]   r_addr;
  logic [4:0]       r_rs1_idx;
  logic [BIT_W-1:0] r_rs1_val;
  logic [4:0]       r_rd;
  logic [BIT_W-1:0] r_pc;

  // Response registers
  logic             r_out_rd_wen;
  logic [BIT_W-1:0] r_out_rdata;
  logic             r_out_redirect;
  logic [BIT_W-1:0] r_out_npc;

  // Combinational decode / datapath
  logic             w_is_csr;
  logic             w_is_ecall;
  logic             w_is_mret;
  logic             w_csr_write;
  logic [BIT_W-1:0] w_operand;
  logic [BIT_W-1:0] w_new;

  logic             w_in_ready;
  logic             w_out_valid;
  logic [R_W-1:0]   w_csr_waddr;
  logic [R_W-1:0]   w_csr_waddr_add1;
  logic [BIT_W-1:0] w_csr_wdata;
  logic [BIT_W-1:0] w_csr_wdata_add1;
  logic             w_csr_wen;
  logic             w_csr_ecallen;
  logic             w_csr_exu_valid;
  logic             w_rd_wen_nxt;
  logic [BIT_W-1:0] w_rdata_nxt;
  logic             w_redirect_nxt;
  logic [BIT_W-1:0] w_npc_nxt;

  // funct3 low bits 0 (encodings 0 and 4) are illegal CSR ops
  assign w_is_csr    = (r_sys == 2'd0) && (r_funct3[1:0] != 2'd0);
  assign w_is_ecall  = (r_sys == 2'd1);
  assign w_is_mret   = (r_sys == 2'd2);
  // Set/clear with a zero source register must not touch the CSR
  assign w_csr_write = w_is_csr && ((r_funct3[1:0] == 2'd1) || (r_rs1_idx != 5'd0));
  assign w_operand   = r_funct3[2] ? BIT_W'(r_rs1_idx) : r_rs1_val;

  // Read-modify-write of the CSR value
  always_comb begin
    w_new = '0;
    case (r_funct3[1:0])
      2'd1:    w_new = w_operand;
      2'd2:    w_new = bus.csr_rdata | w_operand;
      2'd3:    w_new = bus.csr_rdata & ~w_operand;
      default: w_new = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, CSR port drive and response values
  always_comb begin
    w_state_nxt      = r_state;
    w_in_ready       = 1'b0;
    w_out_valid      = 1'b0;
    w_csr_waddr      = r_addr;
    w_csr_waddr_add1 = r_addr;
    w_csr_wdata      = '0;
    w_csr_wdata_add1 = '0;
    w_csr_wen        = 1'b0;
    w_csr_ecallen    = 1'b0;
    w_csr_exu_valid  = 1'b0;
    w_rd_wen_nxt     = 1'b0;
    w_rdata_nxt      = '0;
    w_redirect_nxt   = 1'b0;
    w_npc_nxt        = '0;

    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_EXEC;
      end

      S_EXEC: begin
        w_state_nxt = S_RESP;
        if (w_is_csr) begin
          w_rdata_nxt  = bus.csr_rdata;
          w_rd_wen_nxt = (r_rd != 5'd0);
          if (w_csr_write) begin
            // Both ports carry the same write
            w_csr_wen        = 1'b1;
            w_csr_exu_valid  = 1'b1;
            w_csr_wdata      = w_new;
            w_csr_wdata_add1 = w_new;
          end
        end else if (w_is_ecall) begin
          w_csr_waddr      = MEPC_ADDR;
          w_csr_wdata      = r_pc;
          w_csr_waddr_add1 = MCAUSE_ADDR;
          w_csr_wdata_add1 = MCAUSE_ECALL_M;
          w_csr_wen        = 1'b1;
          w_csr_ecallen    = 1'b1;
          w_csr_exu_valid  = 1'b1;
          w_redirect_nxt   = 1'b1;
          w_npc_nxt        = bus.csr_mtvec;
        end else if (w_is_mret) begin
          w_redirect_nxt = 1'b1;
          w_npc_nxt      = bus.csr_mepc;
        end
      end

      S_RESP: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction latch on accept, response latch at the end of EXEC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sys          <= '0;
      r_funct3       <= '0;
      r_addr         <= '0;
      r_rs1_idx      <= '0;
      r_rs1_val      <= '0;
      r_rd           <= '0;
      r_pc           <= '0;
      r_out_rd_wen   <= 1'b0;
      r_out_rdata    <= '0;
      r_out_redirect <= 1'b0;
      r_out_npc      <= '0;
    end else begin
      if ((r_state == S_IDLE) && bus.in_valid) begin
        r_sys     <= bus.in_sys;
        r_funct3  <= bus.in_funct3;
        r_addr    <= bus.in_csr_addr;
        r_rs1_idx <= bus.in_rs1_idx;
        r_rs1_val <= bus.in_rs1_val;
        r_rd      <= bus.in_rd;
        r_pc      <= bus.in_pc;
      end
      if (r_state == S_EXEC) begin
        r_out_rd_wen   <= w_rd_wen_nxt;
        r_out_rdata    <= w_rdata_nxt;
        r_out_redirect <= w_redirect_nxt;
        r_out_npc      <= w_npc_nxt;
      end
    end
  end

  // in_ready is masked while reset is held so nothing is offered during reset
  assign bus.in_ready       = w_in_ready & rst;
  assign bus.csr_waddr      = w_csr_waddr;
  assign bus.csr_waddr_add1 = w_csr_waddr_add1;
  assign bus.csr_wdata      = w_csr_wdata;
  assign bus.csr_wdata_add1 = w_csr_wdata_add1;
  assign bus.csr_wen        = w_csr_wen;
  assign bus.csr_ecallen    = w_csr_ecallen;
  assign bus.csr_exu_valid  = w_csr_exu_valid;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_rd         = r_rd;
  assign bus.out_rd_wen     = r_out_rd_wen;
  assign bus.out_rdata      = r_out_rdata;
  assign bus.out_redirect   = r_out_redirect;
  assign bus.out_npc        = r_out_npc;

endmodule
